// File: rtl/stall_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: boolean values, default
// geometry, stage indices and the hold-counter width helper.
package stall_ctrl_pkg;

  localparam bit TRUE  = 1'b1;
  localparam bit FALSE = 1'b0;

  localparam int DEF_NUM_STAGES  = 4;
  localparam int DEF_HOLD_CYCLES = 2;
  localparam int DEF_FLUSH_DEPTH = 2;
  localparam int DEF_PERF_W      = 32;

  typedef enum logic [1:0] {
    STG_IF  = 2'd0,
    STG_ID  = 2'd1,
    STG_EX  = 2'd2,
    STG_MEM = 2'd3
  } stage_e;

  // A zero-length hold still needs a one-bit register so the port list stays uniform.
  function automatic int cnt_width(input int hold_cycles);
    return (hold_cycles > 0) ? $clog2(hold_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/stall_hold_cnt.sv
// Post-IF-stall PC hold counter: load to HOLD_CYCLES, clear on redirect,
// otherwise count down to zero. Frozen while en is low.
module stall_hold_cnt
  import stall_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int CNT_W       = cnt_width(HOLD_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  input  logic clear,
  output logic busy
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_CYCLES);

  logic [CNT_W-1:0] cnt;

  // Load beats clear so a stall that coincides with a redirect still re-arms the wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (load) begin
        cnt <= LOAD_VAL;
      end else if (clear) begin
        cnt <= '0;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline hazard controller: per-register hold/bubble/flush strobes with a deferred
// branch flush. Define STALL_PERF_EN to add the saturating stall_cycles counter.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int FLUSH_DEPTH = DEF_FLUSH_DEPTH,
  parameter int PERF_W      = DEF_PERF_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic                  flush_req,
  output logic [NUM_STAGES:0]   hold,
  output logic [NUM_STAGES:0]   bubble,
  output logic [NUM_STAGES:0]   flush,
  output logic                  pc_redirect
`ifdef STALL_PERF_EN
  ,
  output logic [PERF_W-1:0]     stall_cycles
`endif
);

  logic [NUM_STAGES:0] base_hold;
  logic                stall_acc;
  logic                busy;
  logic                pend;
  logic                flush_go;

  // A stalled stage freezes every register upstream of it.
  always_comb begin
    base_hold = '0;
    stall_acc = 1'b0;
    for (int k = NUM_STAGES - 1; k >= 1; k--) begin
      stall_acc    = stall_acc | stall_req[k];
      base_hold[k] = stall_acc;
    end
    base_hold[0] = base_hold[1] | stall_req[STG_IF] | busy;
  end

  // The flush waits until nothing beyond the resolving stage is holding.
  assign flush_go = (flush_req | pend) & ~base_hold[FLUSH_DEPTH+1] & rdy & ~rst;

  always_comb begin
    hold        = base_hold;
    flush       = '0;
    bubble      = '0;
    pc_redirect = FALSE;
    if (flush_go) begin
      for (int k = 0; k <= FLUSH_DEPTH; k++) hold[k] = 1'b0;
      for (int k = 1; k <= FLUSH_DEPTH; k++) flush[k] = 1'b1;
      pc_redirect = TRUE;
    end
    for (int k = 1; k <= NUM_STAGES; k++) begin
      bubble[k] = hold[k-1] & ~hold[k] & ~flush[k];
    end
    if (rst || !rdy) begin
      hold        = '1;
      bubble      = '0;
      flush       = '0;
      pc_redirect = FALSE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= FALSE;
    end else if (!rdy) begin
      pend <= pend | flush_req;
    end else begin
      pend <= (flush_req | pend) & ~flush_go;
    end
  end

  stall_hold_cnt #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (rdy),
    .load  (stall_req[STG_IF]),
    .clear (flush_go),
    .busy  (busy)
  );

`ifdef STALL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (rdy && hold[0] && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`else
  wire unused_perf_w = (PERF_W > 0);
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed plan steps followed by random traffic,
// every cycle compared against a reference model built from the stage rules.
module tb_stall_ctrl;

  localparam int NS = 4;
  localparam int HC = 2;
  localparam int FD = 2;
  localparam int PW = 32;
  localparam int OW = NS + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          rdy;
  logic [NS-1:0] stall_req;
  logic          flush_req;
  logic [NS:0]   hold;
  logic [NS:0]   bubble;
  logic [NS:0]   flush;
  logic          pc_redirect;
`ifdef STALL_PERF_EN
  logic [PW-1:0] stall_cycles;
  logic [PW-1:0] perf_m;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state: cycles of PC wait still owed, and whether a flush is owed.
  int wait_left;
  bit pend_m;
  logic [3*OW:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  stall_ctrl #(
    .NUM_STAGES  (NS),
    .HOLD_CYCLES (HC),
    .FLUSH_DEPTH (FD),
    .PERF_W      (PW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .stall_req   (stall_req),
    .flush_req   (flush_req),
    .hold        (hold),
    .bubble      (bubble),
    .flush       (flush),
    .pc_redirect (pc_redirect)
`ifdef STALL_PERF_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  // ---------------- reference model ----------------
  function automatic int top_stalled(input logic [NS-1:0] sr);
    int t;
    t = -1;
    for (int i = 0; i < NS; i++) if (sr[i]) t = i;
    return t;
  endfunction

  function automatic bit model_go(input logic [NS-1:0] sr, input logic fr);
    return (fr || pend_m) && (top_stalled(sr) <= FD);
  endfunction

  function automatic logic [3*OW:0] predict(input logic [NS-1:0] sr, input logic fr,
                                            input logic rd, input logic rs);
    logic [NS:0] h, b, f;
    logic r;
    int top;
    top = top_stalled(sr);
    h = '1; b = '0; f = '0; r = 1'b0;
    if (!rs && rd) begin
      for (int k = 0; k <= NS; k++) h[k] = (k >= 1) && (k <= top);
      h[0] = (top >= 0) || (wait_left > 0);
      if (model_go(sr, fr)) begin
        for (int k = 0; k <= FD; k++) h[k] = 1'b0;
        for (int k = 1; k <= FD; k++) f[k] = 1'b1;
        r = 1'b1;
      end
      for (int k = 1; k <= NS; k++) b[k] = h[k-1] & ~h[k] & ~f[k];
    end
    return {h, b, f, r};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input string what, input logic [NS:0] got,
                     input logic [NS:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s.%s: got %b expected %b", tag, what, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [NS-1:0] sr, input logic fr, input logic rd,
                      input logic rs, input string tag);
    logic [3*OW:0] e;
    logic [NS:0] eh, eb, ef;
    logic er;
    bit go;
    stall_req = sr;
    flush_req = fr;
    rdy       = rd;
    rst       = rs;
    exp_q.push_back(predict(sr, fr, rd, rs));
    go = !rs && rd && model_go(sr, fr);
    @(negedge clk);
    e = exp_q.pop_front();
    {eh, eb, ef, er} = e;
    chk(tag, "hold", hold, eh);
    chk(tag, "bubble", bubble, eb);
    chk(tag, "flush", flush, ef);
    chk(tag, "pc_redirect", OW'(pc_redirect), OW'(er));
`ifdef STALL_PERF_EN
    if (!rs) begin
      checks++;
      assert (stall_cycles === perf_m)
      else begin
        errors++;
        $error("FAIL %s.stall_cycles: got %0d expected %0d", tag, stall_cycles, perf_m);
      end
    end
`endif
    @(posedge clk);
    if (rs) begin
      wait_left = 0;
      pend_m    = 1'b0;
`ifdef STALL_PERF_EN
      perf_m    = '0;
`endif
    end else if (!rd) begin
      pend_m = pend_m || fr;
    end else begin
`ifdef STALL_PERF_EN
      if (eh[0] && (perf_m != '1)) perf_m = perf_m + 1'b1;
`endif
      if (sr[0]) wait_left = HC;
      else if (go) wait_left = 0;
      else if (wait_left > 0) wait_left = wait_left - 1;
      pend_m = (fr || pend_m) && !go;
    end
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NS-1:0] sr;
    wait_left = 0;
    pend_m    = 1'b0;
`ifdef STALL_PERF_EN
    perf_m    = '0;
`endif
    step('0, 1'b0, 1'b1, 1'b1, "reset0");
    step('0, 1'b1, 1'b1, 1'b1, "reset1");

    for (int i = 0; i < 3; i++) step(4'b1000, 1'b0, 1'b1, 1'b0, "mem_stall");
    step(4'b0000, 1'b0, 1'b1, 1'b0, "mem_release");

    step(4'b0001, 1'b0, 1'b1, 1'b0, "if_stall");
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 1'b1, 1'b0, "if_hold");

    step(4'b0000, 1'b1, 1'b1, 1'b0, "flush_now");
    step(4'b0000, 1'b0, 1'b1, 1'b0, "flush_after");

    step(4'b1000, 1'b1, 1'b1, 1'b0, "flush_blocked");
    step(4'b1000, 1'b0, 1'b1, 1'b0, "flush_wait");
    step(4'b1000, 1'b0, 1'b1, 1'b0, "flush_wait");
    step(4'b0000, 1'b0, 1'b1, 1'b0, "flush_deferred");
    step(4'b0000, 1'b0, 1'b1, 1'b0, "flush_done");

    step(4'b0001, 1'b0, 1'b1, 1'b0, "if_stall2");
    step(4'b0000, 1'b1, 1'b1, 1'b0, "flush_clears_cnt");
    step(4'b0000, 1'b0, 1'b1, 1'b0, "pc_free");

    step(4'b0001, 1'b0, 1'b1, 1'b0, "if_stall3");
    step(4'b0000, 1'b0, 1'b1, 1'b0, "count_down");
    step(4'b0000, 1'b1, 1'b0, 1'b0, "frozen_flush");
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 1'b0, 1'b0, "frozen");
    step(4'b0000, 1'b0, 1'b1, 1'b0, "thaw_flush");
    step(4'b0000, 1'b0, 1'b1, 1'b0, "thaw_after");

    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NS; i++) sr[i] = ($urandom_range(0, 3) == 0);
      step(sr, $urandom_range(0, 5) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 79) == 0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
